// File: rtl/ctrl_multiciclo.sv
// Multicycle processor control FSM: sequences fetch, decode, memory, ALU and branch steps.
// Build option: define CTRL_ILLEGAL_TRAP_EN to lock into TRAP on an unknown opcode (default: NOP).
module ctrl_multiciclo (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       zero,
  output logic [1:0] ALU_OP,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic       illegal,
  output logic [1:0] alu_src_b,
  output logic [3:0] state_dbg
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_EXEC_I    = 4'd8,
    S_ALU_WB    = 4'd9,
    S_BRANCH    = 4'd10,
    S_TRAP      = 4'd11
  } state_t;

  state_t state;
  state_t next_state;

  // The branch decision (pc_write_cond & zero) is made in the datapath.
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state    = state;
    ALU_OP        = 2'b00;
    alu_src_b     = 2'b00;
    alu_src_a     = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    illegal       = 1'b0;

    case (state)
      S_IDLE: next_state = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b10;
        case (opcode)
          OP_LOAD, OP_STORE: next_state = S_MEM_ADDR;
          OP_RTYPE:          next_state = S_EXEC_R;
          OP_ITYPE:          next_state = S_EXEC_I;
          OP_BRANCH:         next_state = S_BRANCH;
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            next_state = S_TRAP;
`else
            illegal    = 1'b1;
            next_state = S_FETCH;
`endif
          end
        endcase
      end
      // Opcode is looked at again here; anything that is no longer a memory op is dropped.
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_LOAD)       next_state = S_MEM_READ;
        else if (opcode == OP_STORE) next_state = S_MEM_WRITE;
        else                         next_state = S_FETCH;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) next_state = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        next_state = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) next_state = S_FETCH;
      end
      S_EXEC_R: begin
        ALU_OP     = 2'b10;
        alu_src_a  = 1'b1;
        next_state = S_ALU_WB;
      end
      S_EXEC_I: begin
        ALU_OP     = 2'b10;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        next_state = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        ALU_OP        = 2'b01;
        alu_src_a     = 1'b1;
        pc_write_cond = 1'b1;
        next_state    = S_FETCH;
      end
      S_TRAP: illegal = 1'b1;
      default: next_state = S_IDLE;
    endcase
  end

  assign state_dbg = state;

endmodule
